// File: rtl/helix4_action_merge_pkg.sv
// Shared types and constants for the four-die action merge.
package helix4_action_merge_pkg;

    localparam int ACTION_W          = 16;
    localparam int SRC_W             = 2;
    localparam int N_SRC             = 4;
    localparam int BURST_MAX_DEFAULT = 4;

    // One buffered beat: the producing die plus its action word.
    typedef struct packed {
        logic [SRC_W-1:0]    src;
        logic [ACTION_W-1:0] data;
    } action_beat_t;

    // Decode a die index into a one-hot ready vector.
    function automatic logic [N_SRC-1:0] onehot4(input logic [SRC_W-1:0] idx);
        logic [N_SRC-1:0] v;
        v      = 4'b0000;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/helix4_action_merge_if.sv
// Per-die input streams and the merged output stream of the action merge.
interface helix4_action_merge_if;
    import helix4_action_merge_pkg::*;

    logic [N_SRC-1:0]               in_valid;
    logic [N_SRC-1:0]               in_ready;
    logic [N_SRC-1:0][ACTION_W-1:0] in_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [ACTION_W-1:0]            out_data;
    logic [SRC_W-1:0]               out_src;

    // Merge block side.
    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );

    // Cluster and downstream consumer side.
    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/helix4_action_merge_fifo2.sv
// Two-entry synchronous FIFO; the head entry drives the outputs straight from a register.
module helix4_action_merge_fifo2 #(
    parameter type T = logic [7:0]
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  T           i_data,
    input  logic       i_pop,
    output T           o_data,
    output logic       o_valid,
    output logic [1:0] o_count
);

    T           r_head;
    T           r_tail;
    logic [1:0] r_count;
    logic       w_pop;
    logic       w_push;

    // Ignore a pop from an empty FIFO and a push into a full one that is not also popping.
    assign w_pop  = i_pop & (r_count != 2'd0);
    assign w_push = i_push & ((r_count < 2'd2) | w_pop);

    // Storage and occupancy update; a push with a pop at count 1 keeps one beat per cycle flowing.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_data;
                    else                 r_tail <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    assign o_data  = r_head;
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/helix4_action_merge.sv
// Round-robin merge of four per-die action streams with a burst lock and a 2-deep output buffer.
module helix4_action_merge
    import helix4_action_merge_pkg::*;
#(
    parameter int BURST_MAX = BURST_MAX_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    helix4_action_merge_if.master bus
);

    localparam int                CNT_W     = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0]  BURST_LIM = CNT_W'(BURST_MAX);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [SRC_W-1:0] r_ptr;
    logic [SRC_W-1:0] w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_ncnt;
    logic [SRC_W-1:0] w_g;
    logic             w_any;
    logic             w_space;
    logic [N_SRC-1:0] w_ready;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count;
    action_beat_t     w_beat;
    action_beat_t     w_head;

    // Pick the first valid die at or after ptr in rotating order; the lowest offset wins.
    always_comb begin
        w_any = 1'b0;
        w_g   = r_ptr;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (bus.in_valid[r_ptr + SRC_W'(k)]) begin
                w_any = 1'b1;
                w_g   = r_ptr + SRC_W'(k);
            end else begin
            end
        end
    end

    // Room is judged from the registered count only, so in_ready never depends on out_ready.
    assign w_space = (w_count < 2'd2);

    // Grant the chosen die only when there is room and the block is out of reset.
    always_comb begin
        if (rst_n && w_space && w_any) w_ready = onehot4(w_g);
        else                           w_ready = 4'b0000;
    end

    assign bus.in_ready = w_ready;
    assign w_push       = |(bus.in_valid & w_ready);
    assign w_pop        = bus.out_valid & bus.out_ready;

    // Burst bookkeeping: extend or close the current burst on acceptance, end it when the owner idles.
    always_comb begin
        w_ptr_nxt = r_ptr;
        w_cnt_nxt = r_cnt;
        w_ncnt    = CNT_ONE;
        if (w_push) begin
            w_ncnt = (w_g == r_ptr) ? (r_cnt + CNT_ONE) : CNT_ONE;
            if (w_ncnt >= BURST_LIM) begin
                w_ptr_nxt = w_g + 2'd1;
                w_cnt_nxt = '0;
            end else begin
                w_ptr_nxt = w_g;
                w_cnt_nxt = w_ncnt;
            end
        end else if ((r_cnt != '0) && !bus.in_valid[r_ptr]) begin
            w_ptr_nxt = r_ptr + 2'd1;
            w_cnt_nxt = '0;
        end else begin
            w_ptr_nxt = r_ptr;
            w_cnt_nxt = r_cnt;
        end
    end

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= 2'd0;
            r_cnt <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign w_beat.src  = w_g;
    assign w_beat.data = bus.in_data[w_g];

    helix4_action_merge_fifo2 #(
        .T (action_beat_t)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (w_push),
        .i_data  (w_beat),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_valid (bus.out_valid),
        .o_count (w_count)
    );

    assign bus.out_data = w_head.data;
    assign bus.out_src  = w_head.src;

endmodule

// File: tb/tb_helix4_action_merge.sv
// Self-checking bench: two merges (burst 4 and burst 1) against a queue-based reference model.
module tb_helix4_action_merge;
    import helix4_action_merge_pkg::*;

    typedef struct {
        logic       rst;
        logic [3:0] en;
        logic       ordy;
        logic [3:0] exp_rdy4;
        logic [3:0] exp_rdy1;
        logic       exp_ov;
        logic [1:0] exp_src4;
        logic [1:0] exp_src1;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    helix4_action_merge_if bus4 ();
    helix4_action_merge_if bus1 ();

    helix4_action_merge #(.BURST_MAX(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    helix4_action_merge #(.BURST_MAX(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: arbiter position, burst length and an ordered queue of buffered beats.
    int           m_ptr [2];
    int           m_cnt [2];
    action_beat_t m_q   [2][$];
    action_beat_t lg    [2][$];
    int           seq   [2][4];
    logic         hold  [2][4];

    logic [3:0]          obs_rdy  [2];
    logic                obs_ov   [2];
    logic [1:0]          obs_src  [2];
    logic [ACTION_W-1:0] obs_data [2];
    logic                obs_acc  [2];

    vec_t tv [23];

    function automatic logic [ACTION_W-1:0] mk(input int s, input int sq);
        logic [ACTION_W-1:0] x;
        x = ACTION_W'(sq % 4096);
        x[ACTION_W-1 -: 2] = 2'(s);
        return x;
    endfunction

    function automatic int pick(input int d, input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(m_ptr[d] + k) % 4]) return (m_ptr[d] + k) % 4;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs at the falling edge, check, step the model across the rising edge.
    task automatic cycle(input logic r, input logic [3:0] en, input logic ordy);
        logic [3:0]   v [2];
        logic [3:0]   exp_rdy;
        logic         exp_ov;
        int           g;
        int           nc;
        int           burst;
        string        tag;
        action_beat_t hd;
        rst_n = r;
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 4; s++) v[d][s] = en[s] | hold[d][s];
        bus4.in_valid  = v[0];
        bus1.in_valid  = v[1];
        for (int s = 0; s < 4; s++) begin
            bus4.in_data[s] = mk(s, seq[0][s]);
            bus1.in_data[s] = mk(s, seq[1][s]);
        end
        bus4.out_ready = ordy;
        bus1.out_ready = ordy;
        #1;
        obs_rdy[0] = bus4.in_ready;  obs_ov[0] = bus4.out_valid;
        obs_src[0] = bus4.out_src;   obs_data[0] = bus4.out_data;
        obs_rdy[1] = bus1.in_ready;  obs_ov[1] = bus1.out_valid;
        obs_src[1] = bus1.out_src;   obs_data[1] = bus1.out_data;
        for (int d = 0; d < 2; d++) begin
            burst = (d == 0) ? 4 : 1;
            tag   = $sformatf("b%0d", burst);
            g     = pick(d, v[d]);
            exp_rdy = (r && g >= 0 && m_q[d].size() < 2) ? 4'(1 << g) : 4'b0000;
            chk({tag, ".in_ready"}, 32'(obs_rdy[d]), 32'(exp_rdy));
            chk({tag, ".rdy_onehot"}, 32'($countones(obs_rdy[d]) <= 1), 32'd1);
            exp_ov = (m_q[d].size() != 0);
            chk({tag, ".out_valid"}, 32'(obs_ov[d]), 32'(exp_ov));
            if (exp_ov) begin
                hd = m_q[d][0];
                chk({tag, ".out_src"}, 32'(obs_src[d]), 32'(hd.src));
                chk({tag, ".out_data"}, 32'(obs_data[d]), 32'(hd.data));
            end
            if (r && obs_ov[d] && ordy) lg[d].push_back('{src: obs_src[d], data: obs_data[d]});
            obs_acc[d] = |(v[d] & obs_rdy[d]);
            if (!r) begin
                m_q[d].delete();
                m_ptr[d] = 0;
                m_cnt[d] = 0;
                for (int s = 0; s < 4; s++) hold[d][s] = 1'b0;
            end else begin
                if (exp_ov && ordy) void'(m_q[d].pop_front());
                if (exp_rdy != 4'b0000) begin
                    m_q[d].push_back('{src: 2'(g), data: mk(g, seq[d][g])});
                    nc = (g == m_ptr[d]) ? m_cnt[d] + 1 : 1;
                    if (nc >= burst) begin
                        m_ptr[d] = (g + 1) % 4;
                        m_cnt[d] = 0;
                    end else begin
                        m_ptr[d] = g;
                        m_cnt[d] = nc;
                    end
                end else if (m_cnt[d] != 0 && !v[d][m_ptr[d]]) begin
                    m_ptr[d] = (m_ptr[d] + 1) % 4;
                    m_cnt[d] = 0;
                end
                for (int s = 0; s < 4; s++) begin
                    if (exp_rdy[s]) begin
                        seq[d][s]++;
                        hold[d][s] = 1'b0;
                    end else begin
                        hold[d][s] = v[d][s];
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        cycle(1'b0, 4'h0, 1'b1);
        cycle(1'b0, 4'h0, 1'b1);
        lg[0].delete();
        lg[1].delete();
    endtask

    initial begin
        int n_acc;
        int s0;
        logic [ACTION_W-1:0] held;
        logic [1:0] exp_idle [8];
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0;
            m_cnt[d] = 0;
            for (int s = 0; s < 4; s++) begin
                seq[d][s]  = 0;
                hold[d][s] = 1'b0;
            end
        end
        bus4.in_valid = 4'h0; bus1.in_valid = 4'h0;
        bus4.in_data  = '0;   bus1.in_data  = '0;
        bus4.out_ready = 1'b0; bus1.out_ready = 1'b0;

        // Reset with all dies valid, then continuous-valid fairness for both burst settings.
        for (int i = 0; i < 3; i++)
            tv[i] = '{1'b0, 4'hF, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 2'd0};
        for (int c = 0; c < 20; c++)
            tv[3 + c] = '{1'b1, 4'hF, 1'b1, 4'(1 << ((c / 4) % 4)), 4'(1 << (c % 4)),
                          (c >= 1), 2'(((c - 1) / 4) % 4), 2'((c - 1) % 4)};

        @(negedge clk);
        for (int i = 0; i < 23; i++) begin
            cycle(tv[i].rst, tv[i].en, tv[i].ordy);
            chk("tbl.rdy4", 32'(obs_rdy[0]), 32'(tv[i].exp_rdy4));
            chk("tbl.rdy1", 32'(obs_rdy[1]), 32'(tv[i].exp_rdy1));
            chk("tbl.ov4", 32'(obs_ov[0]), 32'(tv[i].exp_ov));
            chk("tbl.ov1", 32'(obs_ov[1]), 32'(tv[i].exp_ov));
            if (tv[i].exp_ov) begin
                chk("tbl.src4", 32'(obs_src[0]), 32'(tv[i].exp_src4));
                chk("tbl.src1", 32'(obs_src[1]), 32'(tv[i].exp_src1));
            end else if (!tv[i].rst) begin
                chk("tbl.rst_data", 32'(obs_data[0]), 32'd0);
                chk("tbl.rst_src", 32'(obs_src[0]), 32'd0);
            end
        end

        // Pure round-robin between dies 1 and 3.
        do_reset();
        repeat (8) cycle(1'b1, 4'b1010, 1'b1);
        chk("rr.len", 32'(lg[1].size() >= 6), 32'd1);
        for (int k = 0; k < 6 && k < lg[1].size(); k++)
            chk("rr.src", 32'(lg[1][k].src), (k % 2 == 0) ? 32'd1 : 32'd3);

        // Burst owner goes idle after two beats; priority moves on to die 3.
        exp_idle = '{2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
        do_reset();
        repeat (2) cycle(1'b1, 4'b0100, 1'b1);
        repeat (10) cycle(1'b1, 4'b1001, 1'b1);
        chk("idle.len", 32'(lg[0].size() >= 8), 32'd1);
        for (int k = 0; k < 8 && k < lg[0].size(); k++)
            chk("idle.src", 32'(lg[0][k].src), 32'(exp_idle[k]));

        // Backpressure: two beats absorbed, head held, then drain in order at full rate.
        do_reset();
        s0    = seq[0][0];
        n_acc = 0;
        held  = '0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 4'hF, 1'b0);
            n_acc += int'(obs_acc[0]);
            if (i == 1) held = obs_data[0];
            if (i == 4) begin
                chk("bp.hold_data", 32'(obs_data[0]), 32'(held));
                chk("bp.rdy_low", 32'(obs_rdy[0]), 32'd0);
            end
        end
        chk("bp.accepted", 32'(n_acc), 32'd2);
        repeat (8) cycle(1'b1, 4'hF, 1'b1);
        chk("bp.drain_rate", 32'(lg[0].size()), 32'd8);
        if (lg[0].size() >= 2) begin
            chk("bp.first", 32'(lg[0][0].data), 32'(mk(0, s0)));
            chk("bp.second", 32'(lg[0][1].data), 32'(mk(0, s0 + 1)));
        end

        // Reset with a full buffer: stale beats must never come out.
        do_reset();
        repeat (3) cycle(1'b1, 4'hF, 1'b0);
        chk("mid.full_valid", 32'(obs_ov[0]), 32'd1);
        cycle(1'b0, 4'hF, 1'b0);
        cycle(1'b1, 4'h0, 1'b1);
        chk("mid.valid_cleared", 32'(obs_ov[0]), 32'd0);
        lg[0].delete();
        repeat (3) cycle(1'b1, 4'h0, 1'b1);
        chk("mid.no_stale", 32'(lg[0].size()), 32'd0);
        cycle(1'b1, 4'hF, 1'b1);
        chk("mid.ptr_zero", 32'(obs_rdy[0]), 32'd1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++)
            cycle(($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
